// File: rtl/log_lane_scheduler.sv
// River log scheduler: one sweep per game tick moves live logs left, then a periodic spawn step.
// Optional LOG_LFSR_LANE_EN selects spawn lanes from an 8-bit LFSR instead of round-robin.
module log_lane_scheduler #(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned LANE_BASE_Y  = 64,
  parameter int unsigned LANE_HEIGHT  = 32,
  parameter int unsigned X_START      = 639,
  parameter int unsigned SPAWN_PERIOD = 4
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   timer_done,
  input  logic                   enable,
  input  logic [2:0]             speed_level,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [NUM_SLOTS*11-1:0] slot_x,
  output logic [NUM_SLOTS*11-1:0] slot_y,
  output logic                   busy,
  output logic                   spawn_pulse,
  output logic                   spawn_miss,
  output logic                   tick_overrun
);

  localparam int unsigned IdxW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CntW  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StUpdate = 2'd1;
  localparam logic [1:0] StSpawn  = 2'd2;

  localparam logic [10:0]     XStart  = 11'(X_START);
  localparam logic [10:0]     YBase   = 11'(LANE_BASE_Y);
  localparam logic [CntW-1:0] CntInit = CntW'(SPAWN_PERIOD - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_SLOTS - 1);

  logic [1:0]           state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 pend_q, pend_d;
  logic                 overrun_q, overrun_d;
  logic                 pulse_q, pulse_d;
  logic                 miss_q, miss_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [10:0]          x_q     [NUM_SLOTS];
  logic [10:0]          x_d     [NUM_SLOTS];
  logic [10:0]          y_q     [NUM_SLOTS];
  logic [10:0]          y_d     [NUM_SLOTS];
  logic [3:0]           speed_q [NUM_SLOTS];
  logic [3:0]           speed_d [NUM_SLOTS];

  logic [LaneW-1:0]     spawn_lane;
  logic                 free_found;
  logic [IdxW-1:0]      free_idx;

`ifdef LOG_LFSR_LANE_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  assign spawn_lane = lfsr_q[LaneW-1:0];
`else
  logic [LaneW-1:0] lane_ptr_q, lane_ptr_d;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) lane_ptr_q <= '0;
    else         lane_ptr_q <= lane_ptr_d;
  end

  assign spawn_lane = lane_ptr_q;
`endif

  // Lowest-index free slot, evaluated after the sweep has committed its frees
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    pulse_d   = 1'b0;
    miss_d    = 1'b0;
    cnt_d     = cnt_q;
    active_d  = active_q;
    x_d       = x_q;
    y_d       = y_q;
    speed_d   = speed_q;
`ifndef LOG_LFSR_LANE_EN
    lane_ptr_d = lane_ptr_q;
`endif

    // Ticks arriving mid-sweep are queued one deep; a second one is lost
    if ((state_q != StIdle) && timer_done && enable) begin
      if (pend_q) overrun_d = 1'b1;
      else        pend_d    = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if ((timer_done || pend_q) && enable) begin
          state_d = StUpdate;
          idx_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
        end
      end
      StUpdate: begin
        if (active_q[idx_q]) begin
          if (x_q[idx_q] <= {7'd0, speed_q[idx_q]}) begin
            active_d[idx_q] = 1'b0;
            x_d[idx_q]      = XStart;
          end else begin
            x_d[idx_q] = x_q[idx_q] - {7'd0, speed_q[idx_q]};
          end
        end
        if (idx_q == IdxLast) state_d = StSpawn;
        else                  idx_d   = idx_q + 1'b1;
      end
      StSpawn: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (free_found) begin
          active_d[free_idx] = 1'b1;
          x_d[free_idx]      = XStart;
          y_d[free_idx]      = YBase + 11'(spawn_lane * LANE_HEIGHT);
          speed_d[free_idx]  = {1'b0, speed_level} + 4'd1 + {3'd0, spawn_lane[0]};
          cnt_d              = CntInit;
          pulse_d            = 1'b1;
`ifndef LOG_LFSR_LANE_EN
          lane_ptr_d         = lane_ptr_q + 1'b1;
`endif
        end else begin
          miss_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      pulse_q   <= 1'b0;
      miss_q    <= 1'b0;
      cnt_q     <= CntInit;
      active_q  <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        x_q[i]     <= XStart;
        y_q[i]     <= YBase;
        speed_q[i] <= 4'd1;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      pulse_q   <= pulse_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      x_q       <= x_d;
      y_q       <= y_d;
      speed_q   <= speed_d;
    end
  end

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      slot_x[11*i +: 11] = x_q[i];
      slot_y[11*i +: 11] = y_q[i];
    end
  end

  assign slot_active  = active_q;
  assign busy         = busy_q;
  assign spawn_pulse  = pulse_q;
  assign spawn_miss   = miss_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_log_lane_scheduler.sv
// Scoreboard bench for log_lane_scheduler: a tick-level reference model queues the expected state
// after each sweep; a monitor compares when busy falls.
module tb_log_lane_scheduler;

  localparam int NS = 4;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          timer_done = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    speed_level = 3'd0;
  logic [NS-1:0] slot_active;
  logic [NS*11-1:0] slot_x, slot_y;
  logic          busy, spawn_pulse, spawn_miss, tick_overrun;

  log_lane_scheduler dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .timer_done   (timer_done),
    .enable       (enable),
    .speed_level  (speed_level),
    .slot_active  (slot_active),
    .slot_x       (slot_x),
    .slot_y       (slot_y),
    .busy         (busy),
    .spawn_pulse  (spawn_pulse),
    .spawn_miss   (spawn_miss),
    .tick_overrun (tick_overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NS-1:0]    act;
    logic [NS*11-1:0] x;
    logic [NS*11-1:0] y;
    logic             pulse;
    logic             miss;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state, one entry per slot
  bit m_act [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_spd [NS];
  int m_lane_ptr;
  int m_cnt;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef LOG_LFSR_LANE_EN
  function automatic int lfsr_at(input int k);
    logic [7:0] l;
    l = 8'hA5;
    for (int j = 0; j < k; j++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return int'(l);
  endfunction
`endif

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 639; m_y[i] = 64; m_spd[i] = 1;
    end
    m_lane_ptr = 0;
    m_cnt      = 3;
  endtask

  // One full tick: move, free, then maybe spawn; push the resulting visible state
  task automatic model_sweep(input int spawn_cyc);
    exp_t e;
    int   s, lane;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        if (m_x[i] <= m_spd[i]) begin m_act[i] = 0; m_x[i] = 639; end
        else m_x[i] = m_x[i] - m_spd[i];
      end
    end
    e.pulse = 1'b0;
    e.miss  = 1'b0;
    if (m_cnt != 0) begin
      m_cnt--;
    end else begin
      s = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) s = i;
      if (s < 0) begin
        e.miss = 1'b1;
      end else begin
`ifdef LOG_LFSR_LANE_EN
        lane = lfsr_at(spawn_cyc) % 4;
`else
        lane = m_lane_ptr;
        m_lane_ptr = (m_lane_ptr + 1) % 4;
`endif
        m_act[s] = 1; m_x[s] = 639; m_y[s] = 64 + lane * 32;
        m_spd[s] = int'(speed_level) + 1 + (lane % 2);
        m_cnt = 3;
        e.pulse = 1'b1;
      end
    end
    for (int i = 0; i < NS; i++) begin
      e.act[i]        = m_act[i];
      e.x[11*i +: 11] = 11'(m_x[i]);
      e.y[11*i +: 11] = 11'(m_y[i]);
    end
    sb.push_back(e);
  endtask

  // Monitor: a falling busy outside reset marks a finished sweep
  logic busy_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESETn) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (sb.size() == 0) begin
          check("unexpected_sweep", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("slot_active", 64'(slot_active), 64'(e.act));
          check("slot_x", 64'(slot_x), 64'(e.x));
          check("slot_y", 64'(slot_y), 64'(e.y));
          check("spawn_pulse", 64'(spawn_pulse), 64'(e.pulse));
          check("spawn_miss", 64'(spawn_miss), 64'(e.miss));
        end
      end
      busy_prev = busy;
    end
  end

  task automatic pulse_tick();
    @(posedge CLK); #1;
    timer_done = 1'b1;
    @(posedge CLK); #1;
    timer_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    if (busy) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Tick from IDLE; drive lands one cycle after cyc is read, so SPAWN follows NS+1 edges later
  task automatic do_tick();
    @(posedge CLK); #1;
    if (enable) model_sweep(cyc + NS + 1);
    timer_done = 1'b1;
    @(posedge CLK); #1;
    timer_done = 1'b0;
    if (!enable) check("busy_disabled", 64'(busy), 64'd0);
    wait_idle("sweep");
  endtask

  task automatic check_reset(input string tag);
    logic [NS*11-1:0] xr, yr;
    for (int i = 0; i < NS; i++) begin
      xr[11*i +: 11] = 11'd639;
      yr[11*i +: 11] = 11'd64;
    end
    check({tag, "_active"}, 64'(slot_active), 64'd0);
    check({tag, "_x"}, 64'(slot_x), 64'(xr));
    check({tag, "_y"}, 64'(slot_y), 64'(yr));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pulse"}, 64'(spawn_pulse), 64'd0);
    check({tag, "_miss"}, 64'(spawn_miss), 64'd0);
    check({tag, "_overrun"}, 64'(tick_overrun), 64'd0);
  endtask

  initial begin
    logic [NS*11-1:0] frozen_x;
    int n0;

    model_reset();
    repeat (3) @(posedge CLK);
    #1 check_reset("reset");
    @(negedge CLK) RESETn = 1'b1;

    // Slow directed start: spawn only on every 4th tick, lanes in order
    enable = 1'b1;
    speed_level = 3'd0;
    repeat (14) do_tick();

    // Disabled ticks are dropped and leave positions frozen
    enable = 1'b0;
    frozen_x = slot_x;
    repeat (3) do_tick();
    check("frozen_x", 64'(slot_x), 64'(frozen_x));
    enable = 1'b1;

    // Randomized ticks, speed, enable and gaps
    for (int t = 0; t < 1200; t++) begin
      if ($urandom_range(0, 19) == 0) speed_level = 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 9) != 0);
      do_tick();
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    enable = 1'b1;
    check("no_overrun_yet", 64'(tick_overrun), 64'd0);

    // Back-to-back: tick, pended tick, then a lost tick
    @(posedge CLK); #1;
    n0 = cyc;
    model_sweep(n0 + NS + 1);
    model_sweep(n0 + 2 * NS + 3);
    timer_done = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    timer_done = 1'b0;
    repeat (25) @(posedge CLK);
    #1 check("overrun_set", 64'(tick_overrun), 64'd1);
    check("b2b_drained", 64'(sb.size()), 64'd0);
    do_tick();
    check("overrun_sticky", 64'(tick_overrun), 64'd1);

    // Reset while the sweep is at slot 2
    pulse_tick();
    @(posedge CLK);
    @(posedge CLK);
    #2 RESETn = 1'b0;
    #1 check_reset("midreset");
    model_reset();
    @(negedge CLK);
    @(negedge CLK) RESETn = 1'b1;
    speed_level = 3'd0;
    repeat (5) do_tick();

    repeat (5) @(posedge CLK);
    #1 check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
